// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu : memory stage between execute and writeback.
//   Issues valid/ready data-memory requests and extends returned load data.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_lsu #(
  parameter int XLEN           = 32,
  parameter int NBE            = XLEN / 8,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_alu_res_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic              ex_mem_rd_i,
  input  logic              ex_mem_wr_i,
  input  logic              ex_mem_signed_i,
  input  logic [1:0]        ex_mem_size_i,
  input  logic [4:0]        ex_rd_index_i,
  output logic              dreq_valid_o,
  input  logic              dreq_ready_i,
  output logic [XLEN-1:0]   daddr_o,
  output logic              dwe_o,
  output logic [XLEN-1:0]   dwdata_o,
  output logic [NBE-1:0]    dbe_o,
  input  logic              drsp_valid_i,
  input  logic [XLEN-1:0]   drdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_index_o,
  output logic [XLEN-1:0]   wb_alu_result_o,
  output logic [XLEN-1:0]   wb_rdata_o,
  output logic              wb_mem_access_o,
  output logic              wb_misalign_o,
  output logic              busy_o
);

  localparam int OFFW = $clog2(NBE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [OFFW-1:0] off;
  logic [1:0]      size;
  logic            sgn;
  logic [4:0]      rd;

  logic            ex_mem;
  logic            misalign;
  logic [OFFW-1:0] size_mask;
  logic [XLEN-1:0] eff_addr;
  logic [OFFW-1:0] ex_off;
  logic [NBE-1:0]  be_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  // Alignment mask per size; also used to force alignment when checking is off.
  always_comb begin
    size_mask = '0;
    case (ex_mem_size_i)
      2'b00:   size_mask = OFFW'(0);
      2'b01:   size_mask = OFFW'(1);
      2'b10:   size_mask = OFFW'(3);
      default: size_mask = OFFW'(7);
    endcase
  end

  assign ex_mem   = ex_mem_rd_i | ex_mem_wr_i;
  assign misalign = ex_mem &
                    ((MISALIGN_CHECK && (|(ex_alu_res_i[OFFW-1:0] & size_mask))) ||
                     (XLEN == 32 && ex_mem_size_i == 2'b11));
  assign eff_addr = ex_alu_res_i & ~XLEN'(size_mask);
  assign ex_off   = eff_addr[OFFW-1:0];

  always_comb begin
    be_nxt    = '0;
    wdata_nxt = '0;
    case (ex_mem_size_i)
      2'b00: begin
        be_nxt    = NBE'(1) << ex_off;
        wdata_nxt = {NBE{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        be_nxt    = NBE'(3) << ex_off;
        wdata_nxt = {(NBE/2){ex_store_data_i[15:0]}};
      end
      2'b10: begin
        be_nxt    = NBE'(15) << ex_off;
        wdata_nxt = {(NBE/4){ex_store_data_i[31:0]}};
      end
      default: begin
        be_nxt    = '1;
        wdata_nxt = ex_store_data_i;
      end
    endcase
  end

  // Field extraction is driven only by the captured offset, never by data bits.
  assign shifted = drdata_i >> {off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size)
      2'b00:   load_ext = sgn ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      2'b01:   load_ext = sgn ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      2'b10:   load_ext = sgn ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ex_valid_i && ex_mem && !misalign) state_nxt = REQ;
      REQ:  if (dreq_ready_i) state_nxt = dwe_o ? IDLE : WAIT;
      WAIT: if (drsp_valid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_ready_o   = (state == IDLE);
  assign dreq_valid_o = (state == REQ);
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= IDLE;
      off             <= '0;
      size            <= '0;
      sgn             <= 1'b0;
      rd              <= '0;
      daddr_o         <= '0;
      dwe_o           <= 1'b0;
      dwdata_o        <= '0;
      dbe_o           <= '0;
      wb_valid_o      <= 1'b0;
      wb_rd_index_o   <= '0;
      wb_alu_result_o <= '0;
      wb_rdata_o      <= '0;
      wb_mem_access_o <= 1'b0;
      wb_misalign_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wb_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid_i) begin
            off             <= ex_off;
            size            <= ex_mem_size_i;
            sgn             <= ex_mem_signed_i;
            rd              <= ex_rd_index_i;
            wb_alu_result_o <= ex_alu_res_i;
            wb_mem_access_o <= ex_mem;
            wb_misalign_o   <= misalign;
            wb_rdata_o      <= '0;
            if (!ex_mem || misalign) begin
              wb_valid_o    <= 1'b1;
              wb_rd_index_o <= misalign ? 5'd0 : ex_rd_index_i;
            end else begin
              daddr_o  <= {eff_addr[XLEN-1:OFFW], OFFW'(0)};
              dwe_o    <= ex_mem_wr_i;
              dwdata_o <= wdata_nxt;
              dbe_o    <= be_nxt;
            end
          end
        end
        REQ: begin
          if (dreq_ready_i && dwe_o) begin
            wb_valid_o    <= 1'b1;
            wb_rd_index_o <= rd;
          end
        end
        WAIT: begin
          if (drsp_valid_i) begin
            wb_valid_o    <= 1'b1;
            wb_rd_index_o <= rd;
            wb_rdata_o    <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised memory stage with a valid/ready request channel and a response-latency-tolerant interface to data memory.
- Sits between the execute stage and the writeback stage.
- Supports XLEN of 32 or 64 bits, byte/half/word/double access sizes, byte-lane steering by address, and sign or zero extension of loads.
- Detects misaligned accesses and stalls execute while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width; legal values are 32 or 64.
- NBE, XLEN/8, number of byte lanes. Derived; not overridden.
- MISALIGN_CHECK, 1, when 1 misaligned accesses are flagged and not issued; when 0 the address low bits are masked to size alignment and the access is issued.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- ex_valid_i  in  1  execute stage presents an instruction
- ex_ready_o  out  1  stage can accept an instruction this cycle
- ex_alu_res_i  in  XLEN  ALU result; this is the effective address for loads and stores
- ex_store_data_i  in  XLEN  store data, right-justified
- ex_mem_rd_i  in  1  load
- ex_mem_wr_i  in  1  store (never asserted together with ex_mem_rd_i)
- ex_mem_signed_i  in  1  sign-extend load result
- ex_mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- ex_rd_index_i  in  5  destination register
- dreq_valid_o  out  1  memory request valid
- dreq_ready_i  in  1  memory accepts request
- daddr_o  out  XLEN  request address, aligned down to NBE
- dwe_o  out  1  write request
- dwdata_o  out  XLEN  store data replicated across lanes
- dbe_o  out  NBE  byte enables
- drsp_valid_i  in  1  load data valid
- drdata_i  in  XLEN  load data, full bus width
- wb_valid_o  out  1  one-cycle pulse: result is ready for writeback
- wb_rd_index_o  out  5  destination register (0 on misalign)
- wb_alu_result_o  out  XLEN  registered ALU result
- wb_rdata_o  out  XLEN  extended load data
- wb_mem_access_o  out  1  retired instruction was a load or store
- wb_misalign_o  out  1  retired instruction was a misaligned access
- busy_o  out  1  transaction outstanding (for hazard unit)

Behaviour:
- Reset (asynchronous, reset_i high): state=IDLE; all wb_* outputs are 0; dreq_valid_o=0; dwe_o, daddr_o, dwdata_o and dbe_o are 0; busy_o=0.
- FSM states: IDLE, REQ, WAIT. ex_ready_o=1 only in IDLE.
- IDLE, with ex_valid_i=1:
  - Capture all ex_* inputs into holding registers.
  - Non-memory instruction: next cycle wb_valid_o=1 with wb_mem_access_o=0. Latency is 1 cycle. State stays IDLE.
  - Misaligned access (MISALIGN_CHECK=1): next cycle wb_valid_o=1, wb_misalign_o=1, wb_rd_index_o=0, wb_mem_access_o=1. No memory request is issued.
  - Size 11 with XLEN=32 is always treated as misaligned, regardless of MISALIGN_CHECK.
  - Aligned load or store: go to REQ.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
- REQ:
  - dreq_valid_o=1. Address, data, enables and dwe_o are held stable until dreq_ready_i=1.
  - On acceptance, a store goes to IDLE and asserts wb_valid_o in the next cycle. Store latency is therefore 2 cycles plus request stall cycles.
  - On acceptance, a load goes to WAIT.
- WAIT:
  - Stay in WAIT until drsp_valid_i=1.
  - On response, register the extended data into wb_rdata_o, assert wb_valid_o in the next cycle, and return to IDLE.
  - A response in the same cycle as acceptance is not legal. The earliest response is 1 cycle after acceptance.
- drsp_valid_i received outside WAIT is ignored.
- Lane steering uses the low address bits (off = addr mod NBE). It never uses data bits.
  - Byte: dbe_o = 1<<off.
  - Half: dbe_o = 2'b11<<off.
  - Word: dbe_o = 4'hF<<off.
  - Double: dbe_o is all ones.
  - dwdata_o = store data field replicated NBE/size times.
- Load extraction: the field is drdata_i >> (8*off), truncated to the access size. It is then sign-extended when ex_mem_signed_i=1, otherwise zero-extended, to XLEN. A word load with XLEN=32 is passed through unchanged.
- wb_alu_result_o is the captured ex_alu_res_i for every instruction.
- wb_valid_o is high for exactly 1 cycle per accepted instruction. Writeback applies no backpressure.
- busy_o = (state != IDLE).
- Reset mid-transaction: the FSM returns to IDLE immediately and the outstanding request is abandoned. Any response that arrives later is ignored under the outside-WAIT rule.
- Back-to-back operation: ex_ready_o reasserts in the same cycle that wb_valid_o pulses for the prior memory op. This gives 1 instruction per cycle for non-memory ops.

Test Plan:
- XLEN=32. Signed byte load at address 0x1003, with dreq_ready_i=1 immediately and drsp_valid_i 2 cycles later carrying drdata_i=0x80AB_CDEF. Required: dbe_o=1000, wb_rdata_o=0xFFFF_FF80, wb_valid_o pulses once, and ex_ready_o is 0 for 3 cycles.
- XLEN=32. Unsigned half store of 0x1234_BEEF at address 0x2002, with dreq_ready_i held low for 3 cycles. Required: dreq_valid_o stays high with stable daddr_o=0x2000, dwdata_o=0xBEEF_BEEF and dbe_o=1100; after acceptance, wb_valid_o pulses with wb_mem_access_o=1.
- XLEN=64. Signed word load at address 0x...4 with drdata_i=0x8000_0001_0000_0000. Required: wb_rdata_o=0xFFFF_FFFF_8000_0001.
- Misaligned word load at address 0x1001 (MISALIGN_CHECK=1). Required: dreq_valid_o is never asserted; next cycle wb_valid_o=1, wb_misalign_o=1, wb_rd_index_o=0.
- Three back-to-back ALU ops with rd = 5, 6, 7. Required: wb_valid_o is high for 3 consecutive cycles with those indices, and ex_ready_o stays 1.
- Assert reset_i while in WAIT, then drive drsp_valid_i after reset releases. Required: all outputs return to 0, state is IDLE, and no wb_valid_o pulse occurs.
